keypad_scanner: RTL

Upstream front-end for the access-control state machine ME. Scans a 4x4 matrix keypad and debounces presses. Converts each valid press into the DIGITO/DIGITO_STB/SOLICITUD_ACCESO inputs that ME consumes. One clock domain; the keypad is the only asynchronous source.

---
 rtl/keypad_pkg.sv | 54 +++++
 rtl/keypad_scanner_decoder.sv | 17 +
 rtl/keypad_scanner.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared constants for the 4x4 keypad scanner: FSM encoding, key classes and the key map.
package keypad_pkg;

  localparam logic [2:0] ST_SCAN             = 3'd0;
  localparam logic [2:0] ST_DEBOUNCE         = 3'd1;
  localparam logic [2:0] ST_EMIT             = 3'd2;
  localparam logic [2:0] ST_WAIT_RELEASE     = 3'd3;
  localparam logic [2:0] ST_RELEASE_DEBOUNCE = 3'd4;

  localparam logic [1:0] KEY_DIGIT  = 2'd0;
  localparam logic [1:0] KEY_STAR   = 2'd1;
  localparam logic [1:0] KEY_IGNORE = 2'd2;

  typedef struct packed {
    logic [1:0] cls;
    logic [3:0] value;
  } key_info_t;

  // Index is {row, col}; rows read left to right as columns 0..3.
  function automatic key_info_t key_lookup(input logic [1:0] row, input logic [1:0] col);
    key_info_t k;
    case ({row, col})
      4'h0:    k = '{KEY_DIGIT,  4'd1};
      4'h1:    k = '{KEY_DIGIT,  4'd2};
      4'h2:    k = '{KEY_DIGIT,  4'd3};
      4'h4:    k = '{KEY_DIGIT,  4'd4};
      4'h5:    k = '{KEY_DIGIT,  4'd5};
      4'h6:    k = '{KEY_DIGIT,  4'd6};
      4'h8:    k = '{KEY_DIGIT,  4'd7};
      4'h9:    k = '{KEY_DIGIT,  4'd8};
      4'hA:    k = '{KEY_DIGIT,  4'd9};
      4'hC:    k = '{KEY_STAR,   4'd0};
      4'hD:    k = '{KEY_DIGIT,  4'd0};
      default: k = '{KEY_IGNORE, 4'd0};
    endcase
    return k;
  endfunction

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot4_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_decoder.sv
// Combinational map from captured (row, column) indices to key class and digit value.
module keypad_decoder
  import keypad_pkg::*;
(
  input  logic [1:0] row,
  input  logic [1:0] col,
  output logic [1:0] cls,
  output logic [3:0] value
);

  key_info_t info;

  assign info  = key_lookup(row, col);
  assign cls   = info.cls;
  assign value = info.value;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with press/release debounce producing DIGITO/DIGITO_STB/SOLICITUD_ACCESO.
// Optional KEYPAD_SYNC_EN inserts a 2-flop synchronizer on FILAS (then use SCAN_CYCLES >= 3).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] FILAS,
  output logic [3:0] COLUMNAS,
  output logic [3:0] DIGITO,
  output logic       DIGITO_STB,
  output logic       SOLICITUD_ACCESO
);

  localparam int SW = $clog2(SCAN_CYCLES) + 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  // The SCAN sample is the first match, so debounce needs DEBOUNCE_CYCLES-1 more.
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 2);

  logic [3:0]    rows_s;
  logic [2:0]    state;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] cnt;
  logic [1:0]    row_cap;
  logic [1:0]    col_idx;
  logic [1:0]    key_cls;
  logic [3:0]    key_val;

`ifdef KEYPAD_SYNC_EN
  logic [3:0] sync1;
  logic [3:0] sync2;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1 <= 4'd0;
      sync2 <= 4'd0;
    end else begin
      sync1 <= FILAS;
      sync2 <= sync1;
    end
  end

  assign rows_s = sync2;
`else
  assign rows_s = FILAS;
`endif

  assign col_idx = onehot4_idx(COLUMNAS);

  keypad_decoder u_decoder (
    .row   (row_cap),
    .col   (col_idx),
    .cls   (key_cls),
    .value (key_val)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state            <= ST_SCAN;
      COLUMNAS         <= 4'b0001;
      scan_cnt         <= '0;
      cnt              <= '0;
      row_cap          <= 2'd0;
      DIGITO           <= 4'd0;
      DIGITO_STB       <= 1'b0;
      SOLICITUD_ACCESO <= 1'b0;
    end else begin
      DIGITO_STB       <= 1'b0;
      SOLICITUD_ACCESO <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (is_onehot4(rows_s)) begin
              row_cap <= onehot4_idx(rows_s);
              cnt     <= '0;
              state   <= ST_DEBOUNCE;
            end else begin
              COLUMNAS <= {COLUMNAS[2:0], COLUMNAS[3]};
            end
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (rows_s == (4'd1 << row_cap)) begin
            if (cnt == DEB_LAST) begin
              cnt   <= '0;
              state <= ST_EMIT;
              // Outputs are loaded here so the pulse is visible during the EMIT cycle.
              case (key_cls)
                KEY_DIGIT: begin
                  DIGITO     <= key_val;
                  DIGITO_STB <= 1'b1;
                end
                KEY_STAR: SOLICITUD_ACCESO <= 1'b1;
                default:  ;
              endcase
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt      <= '0;
            state    <= ST_SCAN;
            COLUMNAS <= {COLUMNAS[2:0], COLUMNAS[3]};
          end
        end
        ST_EMIT: state <= ST_WAIT_RELEASE;
        ST_WAIT_RELEASE: begin
          if (rows_s == 4'd0) begin
            cnt   <= '0;
            state <= ST_RELEASE_DEBOUNCE;
          end
        end
        ST_RELEASE_DEBOUNCE: begin
          if (rows_s == 4'd0) begin
            if (cnt == DEB_LAST) begin
              cnt      <= '0;
              scan_cnt <= '0;
              state    <= ST_SCAN;
              COLUMNAS <= {COLUMNAS[2:0], COLUMNAS[3]};
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            state <= ST_WAIT_RELEASE;
          end
        end
        default: begin
          state    <= ST_SCAN;
          COLUMNAS <= 4'b0001;
          scan_cnt <= '0;
          cnt      <= '0;
        end
      endcase
    end
  end

endmodule
